// File: rtl/vga_sync_analyzer.sv
// vga_sync_analyzer: measures incoming VGA sync timing, locks onto it and regenerates pixel/line counters and blanking.
// Define VGA_SYNC_ANALYZER_STATS_EN to add the frameCount/errCount statistics outputs.
module vga_sync_analyzer #(
  parameter int HBP         = 48,
  parameter int HDR         = 640,
  parameter int VBP         = 33,
  parameter int VDR         = 480,
  parameter int LOCK_FRAMES = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        hSyncIn,
  input  logic        vSyncIn,
  output logic [9:0]  pixelCnt,
  output logic [9:0]  lineCnt,
  output logic        compBlank,
  output logic [9:0]  hTotal,
  output logic [9:0]  vTotal,
  output logic        hPolarity,
  output logic        vPolarity,
  output logic        locked,
  output logic        frameStart,
  output logic        syncErr
`ifdef VGA_SYNC_ANALYZER_STATS_EN
  ,
  output logic [15:0] frameCount,
  output logic [7:0]  errCount
`endif
);
  typedef enum logic [1:0] {SEARCH, H_MEAS, V_MEAS, LOCKED} state_t;
  state_t state;
  logic [2:0] hs, vs, v_match;
  logic [9:0] h_cnt, h_last, h_now, v_lines, v_high, v_last, v_now, v_high_now;
  logic [10:0] h_high, h_high_now;
  logic h_last_ok, v_pend, blank_q;
  logic h_lvl, v_lvl, h_rise, h_fall, v_rise, v_fall, h_sat, v_sat, h_pol_now, v_pol_now;
  logic h_bad, v_bad, v_hit, timeout, drop, clr, h_trail, v_trail, wrap;

  assign h_lvl      = hs[1];
  assign v_lvl      = vs[1];
  assign h_rise     = hs[1] & ~hs[2];
  assign h_fall     = ~hs[1] & hs[2];
  assign v_rise     = vs[1] & ~vs[2];
  assign v_fall     = ~vs[1] & vs[2];
  assign h_sat      = &h_cnt;
  assign v_sat      = &v_lines;
  assign h_now      = h_cnt + 10'd1;
  assign h_high_now = h_high + {10'd0, h_lvl};
  assign v_now      = v_sat ? v_lines : v_lines + {9'd0, h_rise};
  assign v_high_now = v_high + {9'd0, h_rise & v_lvl & ~v_sat};
  assign h_pol_now  = {h_high_now, 1'b0} < {2'b00, h_now};
  assign v_pol_now  = {v_high_now, 1'b0} < {1'b0, v_now};
  assign h_bad      = h_rise && (h_sat || h_now != hTotal);
  assign v_bad      = v_rise && v_now != vTotal;
  assign v_hit      = {1'b0, v_match} + 4'd1 >= 4'(LOCK_FRAMES);
  assign timeout    = !h_rise && h_cnt == 10'(TIMEOUT - 1);
  assign drop       = state == LOCKED && (h_bad || v_bad);
  assign clr        = !locked || timeout || drop;
  assign h_trail    = hPolarity ? h_fall : h_rise;
  assign v_trail    = vPolarity ? v_fall : v_rise;
  assign wrap       = !h_trail && pixelCnt == hTotal - 10'd1;
  assign compBlank  = blank_q;
  assign frameStart = locked && pixelCnt == '0 && lineCnt == '0;

  // two synchronizer stages plus one edge-detect stage per sync input
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      hs        <= '0;
      vs        <= '0;
      h_cnt     <= '0;
      h_high    <= '0;
      h_last    <= '0;
      h_last_ok <= 1'b0;
      v_lines   <= '0;
      v_high    <= '0;
      v_last    <= '0;
    end else begin
      hs      <= {hs[1:0], hSyncIn};
      vs      <= {vs[1:0], vSyncIn};
      h_cnt   <= h_rise ? '0 : h_sat ? h_cnt : h_now;
      h_high  <= h_rise ? '0 : h_high_now;
      v_lines <= v_rise ? '0 : v_now;
      v_high  <= v_rise ? '0 : v_high_now;
      if (h_rise) begin
        h_last    <= h_now;
        h_last_ok <= !h_sat;
      end
      if (v_rise) v_last <= v_now;
    end

  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      state     <= SEARCH;
      locked    <= 1'b0;
      syncErr   <= 1'b0;
      hTotal    <= '0;
      vTotal    <= '0;
      hPolarity <= 1'b0;
      vPolarity <= 1'b0;
      v_match   <= '0;
    end else begin
      syncErr <= 1'b0;
      if (timeout || drop) begin
        state   <= SEARCH;
        locked  <= 1'b0;
        syncErr <= state == LOCKED;
      end else
        case (state)
          SEARCH: if (h_rise) state <= H_MEAS;
          H_MEAS:
            if (h_rise && !h_sat && h_last_ok && h_now == h_last) begin
              hTotal    <= h_now;
              hPolarity <= h_pol_now;
              v_match   <= '0;
              state     <= V_MEAS;
            end
          V_MEAS:
            if (v_rise) begin
              if (v_now != v_last) v_match <= '0;
              else if (!v_hit) v_match <= v_match + 3'd1;
              else begin
                vTotal    <= v_now;
                vPolarity <= v_pol_now;
                locked    <= 1'b1;
                state     <= LOCKED;
              end
            end
          default: ;
        endcase
    end

  // a vSync trailing edge takes effect at the next line wrap, including one in the same cycle
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      pixelCnt <= '0;
      lineCnt  <= '0;
      v_pend   <= 1'b0;
      blank_q  <= 1'b1;
    end else if (clr) begin
      pixelCnt <= '0;
      lineCnt  <= '0;
      v_pend   <= 1'b0;
      blank_q  <= 1'b1;
    end else begin
      pixelCnt <= h_trail ? hTotal - 10'(HBP) : wrap ? '0 : pixelCnt + 10'd1;
      if (wrap) lineCnt <= (v_trail || v_pend) ? vTotal - 10'(VBP) : lineCnt == vTotal - 10'd1 ? '0 : lineCnt + 10'd1;
      v_pend  <= !wrap && (v_pend || v_trail);
      blank_q <= pixelCnt >= 10'(HDR) || lineCnt >= 10'(VDR);
    end

`ifdef VGA_SYNC_ANALYZER_STATS_EN
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      frameCount <= '0;
      errCount   <= '0;
    end else begin
      frameCount <= frameCount + {15'd0, frameStart};
      errCount   <= errCount + {7'd0, syncErr && errCount != 8'hff};
    end
`endif
endmodule

// File: tb/tb_vga_sync_analyzer.sv
// tb_vga_sync_analyzer: directed checks of lock, alignment, polarity, stretch, timeout and reset on a reduced 24x14 timing.
module tb_vga_sync_analyzer;
  localparam int HT = 24, VT = 14, FR = HT * VT, TO = 1023;
  logic clock = 1'b0, reset = 1'b1, hSyncIn = 1'b1, vSyncIn = 1'b1;
  logic [9:0] pixelCnt, lineCnt, hTotal, vTotal;
  logic compBlank, hPolarity, vPolarity, locked, frameStart, syncErr;
`ifdef VGA_SYNC_ANALYZER_STATS_EN
  logic [15:0] frameCount;
  logic [7:0] errCount;
`endif
  int gp = 0, gl = 0, n = 0;
  int gph[5], glh[5];
  bit run = 1'b1, inv = 1'b0, stretch = 1'b0;
  int total = 0, passed = 0, fails = 0;

  vga_sync_analyzer #(.HBP(4), .HDR(16), .VBP(2), .VDR(8), .LOCK_FRAMES(2), .TIMEOUT(TO)) dut (
    .clock(clock), .reset(reset), .hSyncIn(hSyncIn), .vSyncIn(vSyncIn),
    .pixelCnt(pixelCnt), .lineCnt(lineCnt), .compBlank(compBlank), .hTotal(hTotal), .vTotal(vTotal),
    .hPolarity(hPolarity), .vPolarity(vPolarity), .locked(locked), .frameStart(frameStart), .syncErr(syncErr)
`ifdef VGA_SYNC_ANALYZER_STATS_EN
    , .frameCount(frameCount), .errCount(errCount)
`endif
  );

  always #5 clock = ~clock;

  // generator: 16 display + 2 front + 2 sync + 4 back pixels; 8 display + 2 front + 2 sync + 2 back lines
  task automatic drive();
    hSyncIn = inv ^ !(gp >= 18 && gp < 20);
    vSyncIn = inv ^ !(gl >= 10 && gl < 12);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    if (run) begin
      if (stretch && gp == HT - 1) stretch = 1'b0;
      else begin
        gp = gp == HT - 1 ? 0 : gp + 1;
        if (gp == 0) gl = gl == VT - 1 ? 0 : gl + 1;
      end
    end
    drive();
    for (int i = 4; i > 0; i--) begin
      gph[i] = gph[i-1];
      glh[i] = glh[i-1];
    end
    gph[0] = gp;
    glh[0] = gl;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cnt"}, {pixelCnt, lineCnt, hTotal}, 0);
    chk({tag, "_vtot"}, vTotal, 0);
    chk({tag, "_flags"}, {locked, syncErr, frameStart, compBlank, hPolarity, vPolarity}, 6'b000100);
  endtask

  task automatic wait_lock(input string tag);
    int k = 0;
    while (!locked && k < 5 * FR) begin
      tick();
      k++;
    end
    chk(tag, locked, 1);
  endtask

  task automatic frame_check(input string tag);
    int fs = 0;
    for (int i = 0; i < FR; i++) begin
      tick();
      chk(tag, {pixelCnt, lineCnt, compBlank, frameStart},
          {10'(gph[3]), 10'(glh[3]), (gph[4] >= 16 || glh[4] >= 8), (gph[3] == 0 && glh[3] == 0)});
      fs += int'(frameStart);
    end
    chk({tag, "_fs_count"}, fs, 1);
  endtask

  initial begin
    drive();
    #2 reset = 1'b0;
    #1 chk_reset("reset");
    repeat (3) tick();
    chk_reset("reset_hold");
    reset = 1'b1;

    wait_lock("lock");
    chk("totals", {hTotal, vTotal}, {10'd24, 10'd14});
    chk("pol_low", {hPolarity, vPolarity}, 0);
    repeat (FR + HT) tick();
    frame_check("align");

    stretch = 1'b1;
    n = 0;
    while (!syncErr && n < 100) begin
      tick();
      n++;
    end
    chk("stretch_err", syncErr, 1);
    chk("stretch_unlock", {locked, compBlank}, 2'b01);
    tick();
    chk("err_pulse", syncErr, 0);
    wait_lock("relock");
    chk("relock_totals", {hTotal, vTotal}, {10'd24, 10'd14});

    for (int i = 0; i < HT && gp != 20; i++) tick();
    run = 1'b0;
    n = 0;
    while (!syncErr && n < 1200) begin
      tick();
      n++;
    end
    chk("timeout_at", n, TO + 3);
    chk("timeout_state", {locked, compBlank, pixelCnt, lineCnt}, {1'b0, 1'b1, 20'd0});
    tick();
    chk("timeout_pulse", syncErr, 0);

    run = 1'b1;
    wait_lock("lock_after_timeout");
    repeat (FR / 2) tick();
    #3 reset = 1'b0;
    #1 chk_reset("async_reset");
    tick();
    chk_reset("reset_held");
    reset = 1'b1;
    wait_lock("lock_after_reset");
    chk("reset_totals", {hTotal, vTotal}, {10'd24, 10'd14});

    reset = 1'b0;
    inv = 1'b1;
    gp = 0;
    gl = 0;
    drive();
    repeat (2) tick();
    reset = 1'b1;
    wait_lock("inv_lock");
    chk("inv_pol", {hPolarity, vPolarity}, 2'b11);
    chk("inv_totals", {hTotal, vTotal}, {10'd24, 10'd14});
    repeat (FR + HT) tick();
    frame_check("inv_align");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
